// File: rtl/cmsdk_ahb_sram_arbiter_pkg.sv
// Shared definitions for the two-master SRAM arbiter.
//   - HTRANS encodings as seen on AHB-Lite
//   - data-phase owner encoding
//   - arbitration policy selectors for the PRIORITY parameter
package cmsdk_ahb_sram_arbiter_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    localparam int PRI_RR    = 0;  // round-robin between contending masters
    localparam int PRI_FIXED = 1;  // M0 always wins a contention

endpackage

// File: rtl/cmsdk_ahb_arb_req_hold.sv
// Per-master request holding register.
// A live address phase that loses arbitration (or finds the slave busy) is
// captured here and replayed later; the master is stalled meanwhile, so at
// most one held request exists per master.
// Ports:
//   clk_i/rst_i      clock, async active-high reset
//   live_i           master presents a valid address phase this cycle
//   grant_i          this master owns the slave address slot this cycle
//   hready_i         slave HREADY (slot actually advances)
//   addr_i/size_i/write_i   live address-phase attributes
//   pend_valid_o     a held request is waiting
//   addr_o/size_o/write_o   attributes to issue: held copy if any, else live
module cmsdk_ahb_arb_req_hold
    import cmsdk_ahb_sram_arbiter_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          live_i,
    input  logic          grant_i,
    input  logic          hready_i,
    input  logic [AW-1:0] addr_i,
    input  logic [2:0]    size_i,
    input  logic          write_i,
    output logic          pend_valid_o,
    output logic [AW-1:0] addr_o,
    output logic [2:0]    size_o,
    output logic          write_o
);

    logic          pend_valid_q, pend_valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    size_q, size_d;
    logic          write_q, write_d;

    always_comb begin
        pend_valid_d = pend_valid_q;
        addr_d       = addr_q;
        size_d       = size_q;
        write_d      = write_q;
        if (pend_valid_q) begin
            // Held request leaves once it is actually placed on the slave.
            if (grant_i && hready_i) pend_valid_d = 1'b0;
        end else if (live_i && !grant_i) begin
            pend_valid_d = 1'b1;
            addr_d       = addr_i;
            size_d       = size_i;
            write_d      = write_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_valid_q <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            write_q      <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            write_q      <= write_d;
        end
    end

    assign pend_valid_o = pend_valid_q;
    assign addr_o       = pend_valid_q ? addr_q  : addr_i;
    assign size_o       = pend_valid_q ? size_q  : size_i;
    assign write_o      = pend_valid_q ? write_q : write_i;

endmodule

// File: rtl/cmsdk_ahb_sram_arbiter.sv
// Two-master AHB-Lite arbiter in front of the SRAM slave.
// M0 (CPU) and M1 (DMA/debug) share one slave port. The losing address phase
// is held and replayed; the losing master is stalled through its HREADYOUT.
// Uncontended transfers pass straight through with no added wait state.
// Ports:
//   HCLK, HRESET                  clock, async active-high reset
//   HSELSx..HREADYSx              master x address/data phase inputs
//   HREADYOUTSx/HRDATASx/HRESPSx  responses to master x
//   HSELM..HREADYM, HMASTERM      request side to the slave
//   HREADYOUTM/HRDATAM/HRESPM     slave response
module cmsdk_ahb_sram_arbiter
    import cmsdk_ahb_sram_arbiter_pkg::*;
#(
    parameter int AW       = 16,
    parameter int PRIORITY = PRI_RR
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSELS0,
    input  logic [AW-1:0] HADDRS0,
    input  logic [1:0]    HTRANSS0,
    input  logic [2:0]    HSIZES0,
    input  logic          HWRITES0,
    input  logic [31:0]   HWDATAS0,
    input  logic          HREADYS0,
    output logic          HREADYOUTS0,
    output logic [31:0]   HRDATAS0,
    output logic          HRESPS0,
    input  logic          HSELS1,
    input  logic [AW-1:0] HADDRS1,
    input  logic [1:0]    HTRANSS1,
    input  logic [2:0]    HSIZES1,
    input  logic          HWRITES1,
    input  logic [31:0]   HWDATAS1,
    input  logic          HREADYS1,
    output logic          HREADYOUTS1,
    output logic [31:0]   HRDATAS1,
    output logic          HRESPS1,
    output logic          HSELM,
    output logic [AW-1:0] HADDRM,
    output logic [1:0]    HTRANSM,
    output logic [2:0]    HSIZEM,
    output logic          HWRITEM,
    output logic [31:0]   HWDATAM,
    output logic          HREADYM,
    input  logic          HREADYOUTM,
    input  logic [31:0]   HRDATAM,
    input  logic          HRESPM,
    output logic          HMASTERM
);

    // BUSY is deliberately not a request: it is treated like IDLE.
    logic live0, live1;
    assign live0 = HSELS0 && HREADYS0 && (HTRANSS0 == HT_NONSEQ || HTRANSS0 == HT_SEQ);
    assign live1 = HSELS1 && HREADYS1 && (HTRANSS1 == HT_NONSEQ || HTRANSS1 == HT_SEQ);

    owner_e owner_q, owner_d;
    logic   last_q, last_d;   // master granted in the last contention (1 = M1)

    logic          pv0, pv1, req0, req1, slot_free, gnt0, gnt1;
    logic [AW-1:0] addr0, addr1;
    logic [2:0]    size0, size1;
    logic          wr0, wr1;

    cmsdk_ahb_arb_req_hold #(.AW(AW)) u_hold0 (
        .clk_i(HCLK), .rst_i(HRESET), .live_i(live0), .grant_i(gnt0), .hready_i(HREADYM),
        .addr_i(HADDRS0), .size_i(HSIZES0), .write_i(HWRITES0),
        .pend_valid_o(pv0), .addr_o(addr0), .size_o(size0), .write_o(wr0)
    );

    cmsdk_ahb_arb_req_hold #(.AW(AW)) u_hold1 (
        .clk_i(HCLK), .rst_i(HRESET), .live_i(live1), .grant_i(gnt1), .hready_i(HREADYM),
        .addr_i(HADDRS1), .size_i(HSIZES1), .write_i(HWRITES1),
        .pend_valid_o(pv1), .addr_o(addr1), .size_o(size1), .write_o(wr1)
    );

    assign req0      = live0 || pv0;
    assign req1      = live1 || pv1;
    // The address slot frees exactly when the slave is ready, which is also
    // the HREADY the slave must see, so the two are the same signal.
    assign slot_free = (owner_q == OWN_NONE) || HREADYOUTM;
    assign HREADYM   = slot_free;

    // Grants are gated by reset so the slave sees nothing while it is held.
    always_comb begin
        gnt1 = !HRESET && slot_free && req1 &&
               (!req0 || (PRIORITY == PRI_RR && !last_q));
        gnt0 = !HRESET && slot_free && req0 && !gnt1;
    end

    always_comb begin
        last_d  = last_q;
        owner_d = owner_q;
        if (PRIORITY == PRI_RR && slot_free && req0 && req1) last_d = gnt1;
        if (HREADYM) begin
            if (gnt0)      owner_d = OWN_M0;
            else if (gnt1) owner_d = OWN_M1;
            else           owner_d = OWN_NONE;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            owner_q <= OWN_NONE;
            last_q  <= 1'b1;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Every issued beat is a NONSEQ single; bursts are broken up.
    always_comb begin
        HSELM   = gnt0 || gnt1;
        HTRANSM = HSELM ? HT_NONSEQ : HT_IDLE;
        HMASTERM = gnt1;
        HADDRM  = '0;
        HSIZEM  = '0;
        HWRITEM = 1'b0;
        if (gnt0) begin
            HADDRM  = addr0;
            HSIZEM  = size0;
            HWRITEM = wr0;
        end else if (gnt1) begin
            HADDRM  = addr1;
            HSIZEM  = size1;
            HWRITEM = wr1;
        end
    end

    always_comb begin
        case (owner_q)
            OWN_M0:  HWDATAM = HWDATAS0;
            OWN_M1:  HWDATAM = HWDATAS1;
            default: HWDATAM = '0;
        endcase
    end

    // A master with a held request is in its data phase from its own point
    // of view, so it sees wait states until the replay reaches the slave.
    assign HREADYOUTS0 = (owner_q == OWN_M0) ? HREADYOUTM : !pv0;
    assign HREADYOUTS1 = (owner_q == OWN_M1) ? HREADYOUTM : !pv1;
    assign HRESPS0     = (owner_q == OWN_M0) && HRESPM;
    assign HRESPS1     = (owner_q == OWN_M1) && HRESPM;
    assign HRDATAS0    = HRDATAM;
    assign HRDATAS1    = HRDATAM;

endmodule

// File: tb/tb_cmsdk_ahb_sram_arbiter.sv
// Bench for cmsdk_ahb_sram_arbiter: two master models, an SRAM slave model
// with per-master wait/error knobs, and scoreboards for slave-side issue
// order and master-side read data.
module tb_cmsdk_ahb_sram_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSELS0, HSELS1, HWRITES0, HWRITES1, HREADYS0, HREADYS1;
    logic [15:0] HADDRS0, HADDRS1, HADDRM;
    logic [1:0]  HTRANSS0, HTRANSS1, HTRANSM;
    logic [2:0]  HSIZES0, HSIZES1, HSIZEM;
    logic [31:0] HWDATAS0, HWDATAS1, HRDATAS0, HRDATAS1, HWDATAM, HRDATAM;
    logic        HREADYOUTS0, HREADYOUTS1, HRESPS0, HRESPS1;
    logic        HSELM, HWRITEM, HREADYM, HREADYOUTM, HRESPM, HMASTERM;
    // fixed-priority instance (slave always ready)
    logic        fRDY0, fRDY1, fRSP0, fRSP1, fSELM, fWRITEM, fREADYM, fMASTERM;
    logic [31:0] fRD0, fRD1, fWDATAM;
    logic [15:0] fADDRM;
    logic [1:0]  fTRANSM;
    logic [2:0]  fSIZEM;

    always #5 HCLK = ~HCLK;

    assign HREADYS0 = HREADYOUTS0;
    assign HREADYS1 = HREADYOUTS1;

    cmsdk_ahb_sram_arbiter #(.AW(16), .PRIORITY(0)) u_dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .HSELS0(HSELS0), .HADDRS0(HADDRS0), .HTRANSS0(HTRANSS0), .HSIZES0(HSIZES0),
        .HWRITES0(HWRITES0), .HWDATAS0(HWDATAS0), .HREADYS0(HREADYS0),
        .HREADYOUTS0(HREADYOUTS0), .HRDATAS0(HRDATAS0), .HRESPS0(HRESPS0),
        .HSELS1(HSELS1), .HADDRS1(HADDRS1), .HTRANSS1(HTRANSS1), .HSIZES1(HSIZES1),
        .HWRITES1(HWRITES1), .HWDATAS1(HWDATAS1), .HREADYS1(HREADYS1),
        .HREADYOUTS1(HREADYOUTS1), .HRDATAS1(HRDATAS1), .HRESPS1(HRESPS1),
        .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HSIZEM(HSIZEM),
        .HWRITEM(HWRITEM), .HWDATAM(HWDATAM), .HREADYM(HREADYM),
        .HREADYOUTM(HREADYOUTM), .HRDATAM(HRDATAM), .HRESPM(HRESPM), .HMASTERM(HMASTERM)
    );

    cmsdk_ahb_sram_arbiter #(.AW(16), .PRIORITY(1)) u_fix (
        .HCLK(HCLK), .HRESET(HRESET),
        .HSELS0(HSELS0), .HADDRS0(HADDRS0), .HTRANSS0(HTRANSS0), .HSIZES0(HSIZES0),
        .HWRITES0(HWRITES0), .HWDATAS0(HWDATAS0), .HREADYS0(HREADYS0),
        .HREADYOUTS0(fRDY0), .HRDATAS0(fRD0), .HRESPS0(fRSP0),
        .HSELS1(HSELS1), .HADDRS1(HADDRS1), .HTRANSS1(HTRANSS1), .HSIZES1(HSIZES1),
        .HWRITES1(HWRITES1), .HWDATAS1(HWDATAS1), .HREADYS1(HREADYS1),
        .HREADYOUTS1(fRDY1), .HRDATAS1(fRD1), .HRESPS1(fRSP1),
        .HSELM(fSELM), .HADDRM(fADDRM), .HTRANSM(fTRANSM), .HSIZEM(fSIZEM),
        .HWRITEM(fWRITEM), .HWDATAM(fWDATAM), .HREADYM(fREADYM),
        .HREADYOUTM(1'b1), .HRDATAM(32'h0), .HRESPM(1'b0), .HMASTERM(fMASTERM)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic        err;
    } txn_t;

    typedef struct packed {
        logic        m;
        logic [15:0] a;
        logic        wr;
    } iss_t;

    txn_t        mq0[$], mq1[$];
    logic [31:0] rdq0[$], rdq1[$];
    iss_t        expq[$];
    txn_t        ap[2], dp[2];
    bit          ap_v[2], dp_v[2];
    bit          s_v, s_m, s_wr, s_err;
    logic [15:0] s_addr;
    int          s_wait;
    int          waitk[2];
    bit          errk[2];
    logic [31:0] mem[0:255], refm[0:255];
    int          n_tests, n_fail;
    int          low0, low1, rsp0, rsp1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic go(input int m, input logic wr, input logic [15:0] a, input logic [31:0] d);
        txn_t t;
        t.addr = a; t.wr = wr; t.wdata = wr ? d : 32'h0; t.err = errk[m];
        if (wr) refm[a[9:2]] = d;
        else if (!t.err) begin
            if (m == 0) rdq0.push_back(refm[a[9:2]]);
            else        rdq1.push_back(refm[a[9:2]]);
        end
        if (m == 0) mq0.push_back(t); else mq1.push_back(t);
    endtask

    task automatic exp_iss(input logic m, input logic [15:0] a, input logic wr);
        iss_t e;
        e.m = m; e.a = a; e.wr = wr;
        expq.push_back(e);
    endtask

    task automatic drive();
        HSELS0   = ap_v[0];
        HTRANSS0 = ap_v[0] ? 2'b10 : 2'b00;
        HADDRS0  = ap_v[0] ? ap[0].addr : 16'h0;
        HWRITES0 = ap_v[0] && ap[0].wr;
        HSIZES0  = 3'b010;
        HWDATAS0 = dp_v[0] ? dp[0].wdata : 32'h0;
        HSELS1   = ap_v[1];
        HTRANSS1 = ap_v[1] ? 2'b10 : 2'b00;
        HADDRS1  = ap_v[1] ? ap[1].addr : 16'h0;
        HWRITES1 = ap_v[1] && ap[1].wr;
        HSIZES1  = 3'b010;
        HWDATAS1 = dp_v[1] ? dp[1].wdata : 32'h0;
        HREADYOUTM = !s_v || (s_wait == 0);
        HRESPM     = s_v && s_err;
        HRDATAM    = (s_v && !s_wr) ? mem[s_addr[9:2]] : 32'h0;
    endtask

    task automatic complete(input int m);
        logic        rsp;
        logic [31:0] rd, e;
        rsp = (m == 0) ? HRESPS0 : HRESPS1;
        rd  = (m == 0) ? HRDATAS0 : HRDATAS1;
        chk($sformatf("resp_m%0d", m), rsp, dp[m].err);
        if (!dp[m].wr && !dp[m].err) begin
            if ((m == 0 && rdq0.size() == 0) || (m == 1 && rdq1.size() == 0))
                chk($sformatf("rdq_underflow_m%0d", m), 1, 0);
            else begin
                e = (m == 0) ? rdq0.pop_front() : rdq1.pop_front();
                chk($sformatf("rdata_m%0d@%h", m, dp[m].addr), rd, e);
            end
        end
    endtask

    task automatic tick();
        bit   l0, l1, rdy;
        iss_t e;
        @(negedge HCLK);
        l0 = HSELS0 && HTRANSS0[1] && HREADYS0;
        l1 = HSELS1 && HTRANSS1[1] && HREADYS1;
        if (!HRESET) begin
            if (l0)      chk("fix_m0_wins", fMASTERM, 0);
            else if (l1) chk("fix_m1_alone", {fSELM, fMASTERM}, 2'b11);
        end
        if (!HREADYOUTS0) low0++;
        if (!HREADYOUTS1) low1++;
        if (HRESPS0) rsp0++;
        if (HRESPS1) rsp1++;
        if (s_v && s_wr) chk("hwdata", HWDATAM, dp[s_m].wdata);
        if (s_v && HREADYOUTM && s_wr && !s_err) mem[s_addr[9:2]] = HWDATAM;
        for (int m = 0; m < 2; m++) begin
            rdy = (m == 0) ? HREADYOUTS0 : HREADYOUTS1;
            if (rdy) begin
                if (dp_v[m]) begin complete(m); dp_v[m] = 0; end
                if (ap_v[m]) begin dp[m] = ap[m]; dp_v[m] = 1; ap_v[m] = 0; end
            end
        end
        if (HREADYM) begin
            if (HSELM && HTRANSM[1]) begin
                chk("htransm", HTRANSM, 2'b10);
                if (expq.size() == 0) chk("issue_unexpected", {HMASTERM, HADDRM}, 0);
                else begin
                    e = expq.pop_front();
                    chk("issue_master", HMASTERM, e.m);
                    chk("issue_addr", HADDRM, e.a);
                    chk("issue_write", HWRITEM, e.wr);
                end
                s_v = 1; s_m = HMASTERM; s_addr = HADDRM; s_wr = HWRITEM;
                s_err = errk[HMASTERM];
                s_wait = s_err ? 1 : waitk[HMASTERM];
            end else s_v = 0;
        end else if (s_v && s_wait > 0) s_wait--;
        @(posedge HCLK);
        #1;
        if (!ap_v[0] && mq0.size() != 0) begin ap[0] = mq0.pop_front(); ap_v[0] = 1; end
        if (!ap_v[1] && mq1.size() != 0) begin ap[1] = mq1.pop_front(); ap_v[1] = 1; end
        drive();
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((mq0.size() != 0 || mq1.size() != 0 || ap_v[0] || ap_v[1] ||
                dp_v[0] || dp_v[1] || s_v) && c < 200) begin
            tick();
            c++;
        end
        if (c >= 200) chk("drain_timeout", c, 0);
        chk("expq_left", expq.size(), 0);
    endtask

    task automatic clr_cnt();
        low0 = 0; low1 = 0; rsp0 = 0; rsp1 = 0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_hselm"}, HSELM, 0);
        chk({tag, "_htransm"}, HTRANSM, 0);
        chk({tag, "_rdy0"}, HREADYOUTS0, 1);
        chk({tag, "_rdy1"}, HREADYOUTS1, 1);
        chk({tag, "_resp"}, {HRESPS0, HRESPS1}, 0);
        chk({tag, "_hmaster"}, HMASTERM, 0);
    endtask

    initial begin
        logic [15:0] a0, a1;
        n_tests = 0; n_fail = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 32'hA500_0000 + i;
            refm[i] = 32'hA500_0000 + i;
        end
        HRESET = 1'b1;
        drive();
        #2 chk_reset_outs("reset");
        repeat (3) @(posedge HCLK);
        #3 HRESET = 1'b0;
        #1 chk_reset_outs("post_reset");

        // single master write then read, no wait states
        clr_cnt();
        go(0, 1, 16'h0040, 32'h1234_5678); exp_iss(0, 16'h0040, 1);
        go(0, 0, 16'h0040, 0);             exp_iss(0, 16'h0040, 0);
        drain();
        chk("s1_low0", low0, 0);

        // simultaneous reads: M0 first after reset, M1 stalled one cycle
        clr_cnt();
        go(0, 0, 16'h0100, 0); exp_iss(0, 16'h0100, 0);
        go(1, 0, 16'h0200, 0); exp_iss(1, 16'h0200, 0);
        drain();
        chk("s2_low1", low1, 1);
        chk("s2_low0", low0, 0);

        // repeated contention alternates; even rounds start with M1
        for (int k = 0; k < 5; k++) begin
            a0 = 16'h0600 + 16'(k * 8);
            a1 = 16'h0604 + 16'(k * 8);
            go(0, 0, a0, 0);
            go(1, 0, a1, 0);
            if (k % 2 == 0) begin exp_iss(1, a1, 0); exp_iss(0, a0, 0); end
            else            begin exp_iss(0, a0, 0); exp_iss(1, a1, 0); end
            drain();
        end

        // M0 write with two wait states, M1 read contending
        clr_cnt();
        waitk[0] = 2;
        go(0, 1, 16'h0300, 32'hCAFE_F00D); exp_iss(0, 16'h0300, 1);
        go(1, 0, 16'h0304, 0);             exp_iss(1, 16'h0304, 0);
        drain();
        chk("s4_low1", low1, 3);
        chk("s4_low0", low0, 2);
        waitk[0] = 0;
        go(0, 0, 16'h0300, 0); exp_iss(0, 16'h0300, 0);
        drain();

        // ERROR response to M1
        clr_cnt();
        errk[1] = 1;
        go(1, 0, 16'h0308, 0); exp_iss(1, 16'h0308, 0);
        drain();
        errk[1] = 0;
        chk("s5_resp1", rsp1, 2);
        chk("s5_resp0", rsp0, 0);
        chk("s5_low1", low1, 1);

        // reset with M1 held and M0 in a waited data phase
        waitk[0] = 3;
        go(0, 1, 16'h0400, 32'h5555_AAAA); exp_iss(0, 16'h0400, 1);
        tick();
        go(1, 0, 16'h0404, 0);
        tick();
        tick();
        chk("pre_rst_rdy0", HREADYOUTS0, 0);
        chk("pre_rst_rdy1", HREADYOUTS1, 0);
        #2 HRESET = 1'b1;
        #1 chk_reset_outs("mid_reset");
        mq0.delete(); mq1.delete(); rdq0.delete(); rdq1.delete(); expq.delete();
        ap_v[0] = 0; ap_v[1] = 0; dp_v[0] = 0; dp_v[1] = 0; s_v = 0;
        waitk[0] = 0;
        drive();
        @(posedge HCLK);
        #3 HRESET = 1'b0;
        #1 chk_reset_outs("rel_reset");

        // first contention after reset goes to M0 again
        clr_cnt();
        go(0, 0, 16'h0500, 0); exp_iss(0, 16'h0500, 0);
        go(1, 0, 16'h0504, 0); exp_iss(1, 16'h0504, 0);
        drain();
        chk("s7_low1", low1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
